// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//   Direct-mapped branch target buffer with a 2-bit saturating direction
//   counter per entry. The fetch stage looks up if_pc combinationally and gets
//   a predicted next PC in the same cycle. The execute stage trains the table
//   with resolved branches one cycle at a time.
//
// Ports
//   clk        : single clock; every table write happens on its rising edge
//   rst        : asynchronous, active-high reset
//   if_pc      : fetch PC being looked up
//   pc_pre     : predicted next PC (32'h0 when there is no prediction)
//   btb_en     : prediction valid (hit and counter in a taken state)
//   upd_en     : a resolved branch/jump trains the table this cycle
//   upd_pc     : PC of the resolved branch
//   upd_taken  : resolved direction
//   upd_target : resolved taken target
// ---------------------------------------------------------------------------
module btb_predictor #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic [31:0] pc_pre,
    output logic        btb_en,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int DEPTH = 2 ** IDX_W;

    // Table state
    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [31:0]       target_q [DEPTH];
    logic [1:0]        ctr_q    [DEPTH];

    logic              valid_d  [DEPTH];
    logic [TAG_W-1:0]  tag_d    [DEPTH];
    logic [31:0]       target_d [DEPTH];
    logic [1:0]        ctr_d    [DEPTH];

    // Address decomposition; pc[1:0] never participates
    logic [IDX_W-1:0]  lk_idx_s;
    logic [TAG_W-1:0]  lk_tag_s;
    logic [IDX_W-1:0]  up_idx_s;
    logic [TAG_W-1:0]  up_tag_s;
    logic              lk_hit_s;
    logic              up_hit_s;

    assign lk_idx_s = if_pc[IDX_W+1:2];
    assign lk_tag_s = if_pc[31:IDX_W+2];
    assign up_idx_s = upd_pc[IDX_W+1:2];
    assign up_tag_s = upd_pc[31:IDX_W+2];

    // Zero-latency lookup; reads the registered table, so a same-cycle update
    // to this index is only visible from the next cycle on
    always_comb begin
        lk_hit_s = valid_q[lk_idx_s] && (tag_q[lk_idx_s] == lk_tag_s);
        btb_en   = lk_hit_s && ctr_q[lk_idx_s][1];
        if (btb_en) begin
            pc_pre = target_q[lk_idx_s];
        end else begin
            pc_pre = 32'h0000_0000;
        end
    end

    // Next-state for the training port; only the addressed entry can change
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        up_hit_s = valid_q[up_idx_s] && (tag_q[up_idx_s] == up_tag_s);
        if (upd_en) begin
            if (up_hit_s) begin
                if (upd_taken) begin
                    target_d[up_idx_s] = upd_target;
                    if (ctr_q[up_idx_s] != 2'b11) begin
                        ctr_d[up_idx_s] = ctr_q[up_idx_s] + 2'b01;
                    end else begin
                        ctr_d[up_idx_s] = 2'b11;
                    end
                end else begin
                    if (ctr_q[up_idx_s] != 2'b00) begin
                        ctr_d[up_idx_s] = ctr_q[up_idx_s] - 2'b01;
                    end else begin
                        ctr_d[up_idx_s] = 2'b00;
                    end
                end
            end else if (upd_taken) begin
                // Allocate over whatever occupies this slot, weakly taken
                valid_d[up_idx_s]  = 1'b1;
                tag_d[up_idx_s]    = up_tag_s;
                target_d[up_idx_s] = upd_target;
                ctr_d[up_idx_s]    = 2'b10;
            end else begin
                // Not-taken branches that miss are not worth a slot
                valid_d[up_idx_s] = valid_q[up_idx_s];
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Table registers; reset empties the table and parks counters weakly not-taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= 32'h0000_0000;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic [31:0] pc_pre;
    logic        btb_en;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    int total;
    int bad;

    btb_predictor dut (
        .clk        (clk),
        .rst        (rst),
        .if_pc      (if_pc),
        .pc_pre     (pc_pre),
        .btb_en     (btb_en),
        .upd_en     (upd_en),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One training cycle: drive after a falling edge, write at the rising edge,
    // return at the next falling edge with upd_en low.
    task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        upd_en     = 1'b1;
        upd_pc     = pc;
        upd_taken  = tk;
        upd_target = tgt;
        @(posedge clk);
        #1;
        upd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_pred(input string name, input logic [31:0] pc,
                               input logic exp_en, input logic [31:0] exp_pc);
        if_pc = pc;
        #1;
        total++;
        if (btb_en !== exp_en || pc_pre !== exp_pc) begin
            bad++;
            $display("FAIL %s pc=%h btb_en=%b pc_pre=%h required btb_en=%b pc_pre=%h",
                     name, pc, btb_en, pc_pre, exp_en, exp_pc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        upd_en = 1'b0;
        upd_pc = 32'h0;
        upd_taken = 1'b0;
        upd_target = 32'h0;
        if_pc = 32'h0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            if_pc = (i * 4) + (i % 4);
            #1;
            total++;
            if (btb_en !== 1'b0 || pc_pre !== 32'h0) begin
                bad++;
                $display("FAIL reset_sweep pc=%h btb_en=%b pc_pre=%h required 0/00000000",
                         if_pc, btb_en, pc_pre);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 64; i++) begin
            if_pc = 32'h0000_0100 + (i * 4);
            #1;
            total++;
            if (btb_en !== 1'b0 || pc_pre !== 32'h0) begin
                bad++;
                $display("FAIL post_reset_sweep pc=%h btb_en=%b pc_pre=%h required 0/00000000",
                         if_pc, btb_en, pc_pre);
            end
        end
    endtask

    task automatic test_alloc;
        // Miss and not taken must not allocate
        do_update(32'h0000_0100, 1'b0, 32'h0000_0999);
        expect_pred("miss_nt_no_alloc", 32'h0000_0100, 1'b0, 32'h0);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("alloc_hit", 32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("alloc_low_bits2", 32'h0000_0102, 1'b1, 32'h0000_0200);
        expect_pred("alloc_low_bits1", 32'h0000_0101, 1'b1, 32'h0000_0200);
        expect_pred("alloc_neighbor", 32'h0000_0104, 1'b0, 32'h0);
        // Second entry at index 1, must survive later traffic on index 0
        do_update(32'h0000_0104, 1'b1, 32'h0000_0500);
        expect_pred("alloc_idx1", 32'h0000_0104, 1'b1, 32'h0000_0500);
        expect_pred("idx0_untouched", 32'h0000_0100, 1'b1, 32'h0000_0200);
    endtask

    task automatic test_counter;
        // Entry at 0x100 starts at ctr=10
        do_update(32'h0000_0100, 1'b0, 32'h0);
        expect_pred("ctr_10_to_01", 32'h0000_0100, 1'b0, 32'h0);
        do_update(32'h0000_0100, 1'b0, 32'h0);
        expect_pred("ctr_01_to_00", 32'h0000_0100, 1'b0, 32'h0);
        do_update(32'h0000_0100, 1'b0, 32'h0);
        expect_pred("ctr_sat_00", 32'h0000_0100, 1'b0, 32'h0);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("ctr_00_to_01", 32'h0000_0100, 1'b0, 32'h0);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("ctr_01_to_10", 32'h0000_0100, 1'b1, 32'h0000_0200);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("ctr_sat_11", 32'h0000_0100, 1'b1, 32'h0000_0200);
        // From 11 one not-taken leaves it taken; a wrap to 00 would not
        do_update(32'h0000_0100, 1'b0, 32'h0);
        expect_pred("ctr_11_to_10", 32'h0000_0100, 1'b1, 32'h0000_0200);
        do_update(32'h0000_0100, 1'b0, 32'h0);
        expect_pred("ctr_10_to_01_b", 32'h0000_0100, 1'b0, 32'h0);
        expect_pred("idx1_after_ctr", 32'h0000_0104, 1'b1, 32'h0000_0500);
    endtask

    task automatic test_alias;
        // 0x100 is at ctr=01: a taken hit moves it to 10
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("alias_pre", 32'h0000_0100, 1'b1, 32'h0000_0200);
        do_update(32'h0000_0140, 1'b1, 32'h0000_0300);
        expect_pred("alias_old_miss", 32'h0000_0100, 1'b0, 32'h0);
        expect_pred("alias_new_hit", 32'h0000_0140, 1'b1, 32'h0000_0300);
        // Not-taken from the evicted tag is a miss and must not touch 0x140
        do_update(32'h0000_0100, 1'b0, 32'h0);
        expect_pred("alias_miss_nt", 32'h0000_0140, 1'b1, 32'h0000_0300);
        expect_pred("alias_idx1", 32'h0000_0104, 1'b1, 32'h0000_0500);
    endtask

    task automatic test_back_to_back;
        do_update(32'h0000_0100, 1'b1, 32'h0000_0200);
        expect_pred("hazard_setup", 32'h0000_0100, 1'b1, 32'h0000_0200);
        if_pc      = 32'h0000_0100;
        upd_en     = 1'b1;
        upd_pc     = 32'h0000_0100;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_0400;
        #1;
        total++;
        if (btb_en !== 1'b1 || pc_pre !== 32'h0000_0200) begin
            bad++;
            $display("FAIL hazard_same_cycle btb_en=%b pc_pre=%h required 1/00000200", btb_en, pc_pre);
        end
        @(posedge clk);
        #1;
        upd_en = 1'b0;
        total++;
        if (btb_en !== 1'b1 || pc_pre !== 32'h0000_0400) begin
            bad++;
            $display("FAIL hazard_next_cycle btb_en=%b pc_pre=%h required 1/00000400", btb_en, pc_pre);
        end
        @(negedge clk);
        // Garbage on the update bus while disabled must be ignored
        upd_pc     = 32'hxxxx_xxxx;
        upd_taken  = 1'bx;
        upd_target = 32'hxxxx_xxxx;
        repeat (3) @(negedge clk);
        upd_pc     = 32'h0000_0100;
        upd_taken  = 1'b0;
        upd_target = 32'h0;
        repeat (2) @(negedge clk);
        expect_pred("idle_x_idx0", 32'h0000_0100, 1'b1, 32'h0000_0400);
        expect_pred("idle_x_idx1", 32'h0000_0104, 1'b1, 32'h0000_0500);
    endtask

    task automatic test_async_reset;
        if_pc = 32'h0000_0104;
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (btb_en !== 1'b0 || pc_pre !== 32'h0) begin
            bad++;
            $display("FAIL async_reset btb_en=%b pc_pre=%h required 0/00000000", btb_en, pc_pre);
        end
        // Update pulse across a rising edge while reset is held
        upd_en     = 1'b1;
        upd_pc     = 32'h0000_0200;
        upd_taken  = 1'b1;
        upd_target = 32'h0000_0700;
        @(posedge clk);
        #1;
        upd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        expect_pred("rst_wins_200", 32'h0000_0200, 1'b0, 32'h0);
        expect_pred("rst_cleared_100", 32'h0000_0100, 1'b0, 32'h0);
        expect_pred("rst_cleared_104", 32'h0000_0104, 1'b0, 32'h0);
        // First edge after release must accept an update
        do_update(32'h0000_0180, 1'b1, 32'h0000_0600);
        expect_pred("post_rst_update", 32'h0000_0180, 1'b1, 32'h0000_0600);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alloc();
        test_counter();
        test_alias();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 Parameter IDX_W, default 4, SHALL set table depth to 2**IDX_W entries, direct-mapped.
REQ-002 Parameter TAG_W, default 30-IDX_W, SHALL be the stored tag width, taken from pc[31:IDX_W+2].
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 if_pc  input  32  fetch-stage PC being looked up.
REQ-006 pc_pre  output  32  predicted next PC for if_pc.
REQ-007 btb_en  output  1  prediction valid; next-PC selection takes pc_pre when 1 and no flush is pending.
REQ-008 upd_en  input  1  a branch or jump resolved in EX this cycle; caller gates it with stall and flush.
REQ-009 upd_pc  input  32  PC of the resolved branch.
REQ-010 upd_taken  input  1  actual direction of the resolved branch.
REQ-011 upd_target  input  32  actual taken target.

Function
REQ-012 Each entry SHALL hold valid (1), tag (TAG_W), target (32) and a 2-bit saturating counter ctr.
REQ-013 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] SHALL be ignored for both lookup and update.
REQ-014 Lookup SHALL be combinational, zero latency: hit = valid && tag match at if_pc's index.
REQ-015 btb_en SHALL be hit && ctr[1].
REQ-016 pc_pre SHALL be the entry target when btb_en=1, else 32'h0.
REQ-017 Update SHALL occur on the clk edge when upd_en=1, and only then.
REQ-018 Update, hit and taken: target <= upd_target; ctr <= min(ctr+1, 2'b11).
REQ-019 Update, hit and not taken: ctr <= max(ctr-1, 2'b00); target unchanged; valid stays 1.
REQ-020 Update, miss and taken: allocate the entry (overwrite any occupant): valid<=1, tag<=upd tag, target<=upd_target, ctr<=2'b10.
REQ-021 Update, miss and not taken: no state change.
REQ-022 Counter saturation: increment at 2'b11 stays 2'b11; decrement at 2'b00 stays 2'b00; no wrap.
REQ-023 Same-cycle lookup and update to the same index: lookup SHALL return pre-update contents; no write-to-read bypass.
REQ-024 Updates to other indices SHALL leave all other entries bit-identical.
REQ-025 Aliasing: a different tag at the same index SHALL miss (btb_en=0) until reallocated.
REQ-026 An X or 0 value on upd_pc/upd_taken/upd_target while upd_en=0 SHALL not affect state.

Reset
REQ-027 rst=1 SHALL immediately, without waiting for clk, clear every valid bit and set every ctr to 2'b01; targets and tags are don't-care.
REQ-028 During and after reset until the first allocation, btb_en SHALL be 0 and pc_pre SHALL be 32'h0 for any if_pc.
REQ-029 rst asserted in the same cycle as upd_en SHALL win; no entry is written.
REQ-030 rst deasserted mid-stream SHALL accept updates from the first following rising edge.

Verification
REQ-031 Reset, then sweep if_pc over 64 addresses -> btb_en=0 and pc_pre=0 for all.
REQ-032 Update pc=0x100, taken, target=0x200; then if_pc=0x100 -> btb_en=1, pc_pre=0x200; if_pc=0x102 -> same result (low bits ignored).
REQ-033 From ctr=10 at 0x100: two not-taken updates -> btb_en=0 after the first (ctr=01) and after the second (ctr=00); a third not-taken keeps ctr=00; then two taken updates are needed before btb_en=1.
REQ-034 Alias: allocate 0x100 -> 0x200, then taken update 0x140 -> 0x300 (same index with IDX_W=4) -> if_pc=0x100 gives btb_en=0; if_pc=0x140 gives pc_pre=0x300.
REQ-035 Same-cycle hazard: if_pc=0x100 with a taken update of 0x100 to a new target 0x400 -> that cycle shows old target 0x200; the next cycle shows 0x400.
REQ-036 Assert rst asynchronously between edges with valid entries -> btb_en drops to 0 before the next clk edge; an upd_en pulse coinciding with rst leaves the table empty.
